// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter: round-robin owner of a 2-to-4 decoder's select/enable pair.
// Four level requesters share the decoder. An owner keeps it until it signals
// done or drops its request. A one-cycle dead gap separates successive owners.
// Optional hold-time limit with forced release is enabled by defining
// RR_ARB_TIMEOUT_EN; without it, timeout is tied low and HOLD_MAX is ignored.
module rr_dec_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] s,
    output logic       e,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // The hold counter is 8 bits wide, so only 1..255 is meaningful.
    if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_bad_hold_max
        $error("rr_dec_arbiter: HOLD_MAX must be in 1..255");
    end

    state_t     state_reg;
    logic [1:0] s_reg;
    logic       e_reg;
    logic       busy_reg;
    logic [1:0] ptr_reg;

    logic       win_valid;
    logic [1:0] win_idx;
    logic       user_release;
    logic       force_release;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);
    logic [7:0] hold_cnt_reg;
    logic       timeout_reg;
`endif

    // Round-robin search: the lowest offset from ptr with a request set wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_reg + 2'(k)]) begin
                win_valid = 1'b1;
                win_idx   = ptr_reg + 2'(k);
            end
        end
    end

    // Release causes while granted; done/withdrawal override the hold limit.
    always_comb begin
        user_release = done || !req[s_reg];
`ifdef RR_ARB_TIMEOUT_EN
        force_release = !user_release && (hold_cnt_reg == HOLD_LIMIT);
`else
        force_release = 1'b0;
`endif
    end

    // Ownership FSM with registered decoder select/enable and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            s_reg        <= 2'd0;
            e_reg        <= 1'b0;
            busy_reg     <= 1'b0;
            ptr_reg      <= 2'd0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            // The timeout pulse lives only for the gap cycle after a forced release.
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE, GAP: begin
                    if (win_valid) begin
                        state_reg    <= GRANT;
                        s_reg        <= win_idx;
                        e_reg        <= 1'b1;
                        busy_reg     <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt_reg <= 8'd1;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                GRANT: begin
                    if (user_release || force_release) begin
                        state_reg   <= GAP;
                        e_reg       <= 1'b0;
                        busy_reg    <= 1'b0;
                        ptr_reg     <= s_reg + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
                        timeout_reg <= force_release;
`endif
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    e_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Decoded one-hot grant straight from the registered select/enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
        assign gnt[gi] = e_reg && (s_reg == 2'(gi));
    end

    assign s    = s_reg;
    assign e    = e_reg;
    assign busy = busy_reg;

`ifdef RR_ARB_TIMEOUT_EN
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

endmodule
